bp_cfg_loader: RTL
==================

# bp_cfg_loader

Sequencer that programs per-tile configuration registers after reset, generalising the static per-configuration parameter sets into runtime-programmable per-tile state. It sits between the host/boot logic and the config link of every tile. For each tile it issues a parametrised table of config writes, then an auto-generated core-id write. After all tiles are programmed, it broadcasts an unfreeze write to each tile. It provides valid/ready backpressure handling, per-entry masking and a stall timeout.

## Interface
Parameters:
- num_tiles_p, 4: tiles to program (≥1); tile_id width = `BSG_SAFE_CLOG2(num_tiles_p)`.
- num_entries_p, 8: table entries written to each tile (≥1).
- cfg_addr_width_p, 16: config address width.
- cfg_data_width_p, 64: config data width.
- core_id_addr_p, 16'h0004: address of the per-tile core-id register.
- freeze_addr_p, 16'h0002: address of the per-tile freeze register.
- timeout_p, 1024: stall limit in cycles; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  single-cycle start request.
- cfg_table_i  in  num_entries_p*(cfg_addr_width_p+cfg_data_width_p)  entry e = {addr,data} at slice e; held static while busy.
- cfg_mask_i  in  num_entries_p  1 = entry e enabled.
- cfg_v_o  out  1  write valid.
- cfg_ready_i  in  1  tile link accepts the write.
- cfg_tile_o  out  tile_id width  destination tile.
- cfg_addr_o  out  cfg_addr_width_p  write address.
- cfg_data_o  out  cfg_data_width_p  write data.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence completed; sticky until the next start.
- error_o  out  1  timeout occurred; sticky until reset.

## Operation
- States: IDLE, ENTRY, CORE_ID, UNFREEZE, DONE, ERROR.
- Counters:
  - tile_r runs 0..num_tiles_p-1.
  - entry_r runs 0..num_entries_p-1.
  - stall_r is a timeout counter.
- IDLE/DONE + start_i → ENTRY. Entering ENTRY sets tile_r=0, entry_r=0 and clears done_o. start_i is ignored in ENTRY, CORE_ID, UNFREEZE and ERROR.
- ENTRY behaviour:
  - If cfg_mask_i[entry_r]=1: cfg_v_o=1, tile=tile_r, addr/data = table slice entry_r. Advance on handshake (cfg_v_o & cfg_ready_i).
  - If the mask bit is 0: cfg_v_o=0. Advance unconditionally after one cycle.
  - After the last entry → CORE_ID.
- CORE_ID: writes addr=core_id_addr_p, data=zero-extended tile_r. On handshake:
  - If tile_r < num_tiles_p-1: tile_r+1, entry_r=0, → ENTRY.
  - Otherwise: tile_r=0, → UNFREEZE.
- UNFREEZE: writes addr=freeze_addr_p, data=0 to tile_r. On handshake, tile_r increments. After the last tile → DONE and done_o=1.
- Handshake rules:
  - While cfg_v_o=1 and cfg_ready_i=0, cfg_tile_o, cfg_addr_o and cfg_data_o hold stable.
  - cfg_v_o never drops without a handshake, except on a timeout or reset.
- Timeout:
  - stall_r increments each cycle with cfg_v_o & ~cfg_ready_i, and clears on any handshake or unvalid cycle.
  - If timeout_p≠0 and stall_r reaches timeout_p-1 while still stalled → ERROR on the next edge: cfg_v_o=0, error_o=1, busy_o=0.
  - ERROR is left only by reset.
- busy_o = state ∈ {ENTRY, CORE_ID, UNFREEZE}.
- Output timing: cfg_* outputs are combinational from registered state/counters/table. They carry no combinational dependence on cfg_ready_i.
- Reset (asynchronous, any time): state=IDLE, all counters 0, cfg_v_o=0, cfg_tile_o/addr/data=0, busy_o=0, done_o=0, error_o=0. A write in flight is abandoned.

## Timing
- start_i sampled at edge k → cfg_v_o may be high in cycle k+1.
- With cfg_ready_i=1 and all entries enabled, throughput is one write per cycle.
  - Total writes W = num_tiles_p*(num_entries_p+2).
  - done_o rises the cycle after the last handshake.
- Each masked entry costs exactly one idle cycle per tile.
- Restart: start_i in DONE restarts at tile 0, entry 0, one cycle later.
- Timeout: with ready held low from the cycle valid rises (cycle v), error_o is high from cycle v+timeout_p.

## Test plan
- num_tiles_p=2, num_entries_p=2, table={(0x10,0xA),(0x20,0xB)}, mask=2'b11, ready=1, start at cycle 0:
  - Writes in cycles 1..8 are (t0,0x10,A), (t0,0x20,B), (t0,0x4,0), (t1,0x10,A), (t1,0x20,B), (t1,0x4,1), (t0,0x2,0), (t1,0x2,0).
  - done_o=1 at cycle 9.
- Same setup with ready toggling 0/1 every cycle: the same 8 writes in the same order, fields stable during every stall, done_o the cycle after the last handshake.
- mask=2'b01: 0x20 writes absent, one idle cycle per tile, 6 writes total.
- timeout_p=4, ready stuck 0 after start: error_o=1 and cfg_v_o=0 four cycles after valid rises; start_i afterwards is ignored until reset.
- reset_n_i pulsed low during tile 1's ENTRY: all outputs are 0 immediately (asynchronous). After release and start, the sequence restarts from tile 0.
- After done_o, pulse start_i again: done_o clears and the identical write sequence repeats.

Source files
------------

// File: rtl/bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : bp_cfg_loader
// Description : Post-reset configuration sequencer. Walks every tile, issues
//               the masked table of config writes followed by a core-id
//               write, then broadcasts an unfreeze write to each tile.
//               Valid/ready handshake on the config link, stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cfg_loader #(
  parameter int num_tiles_p      = 4,
  parameter int num_entries_p    = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter logic [cfg_addr_width_p-1:0] core_id_addr_p = cfg_addr_width_p'(16'h0004),
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p  = cfg_addr_width_p'(16'h0002),
  parameter int timeout_p        = 1024,
  localparam int c_tile_w        = (num_tiles_p > 1) ? $clog2(num_tiles_p) : 1
) (
  input  logic                                                      clk_i,
  input  logic                                                      reset_n_i,
  input  logic                                                      start_i,
  input  logic [num_entries_p*(cfg_addr_width_p+cfg_data_width_p)-1:0] cfg_table_i,
  input  logic [num_entries_p-1:0]                                  cfg_mask_i,
  output logic                                                      cfg_v_o,
  input  logic                                                      cfg_ready_i,
  output logic [c_tile_w-1:0]                                       cfg_tile_o,
  output logic [cfg_addr_width_p-1:0]                               cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                               cfg_data_o,
  output logic                                                      busy_o,
  output logic                                                      done_o,
  output logic                                                      error_o
);

  localparam int c_entry_w = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
  localparam int c_stall_w = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam int c_ent_w   = cfg_addr_width_p + cfg_data_width_p;

  localparam logic [c_tile_w-1:0]  c_last_tile  = c_tile_w'(num_tiles_p - 1);
  localparam logic [c_entry_w-1:0] c_last_entry = c_entry_w'(num_entries_p - 1);
  // Stall count at which a still-stalled write trips the timeout
  localparam logic [c_stall_w-1:0] c_stall_lim  =
      (timeout_p > 0) ? c_stall_w'(timeout_p - 1) : '0;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CORE_ID  = 3'd2;
  localparam logic [2:0] S_UNFREEZE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  logic [2:0]                  r_state, w_state_next;
  logic [c_tile_w-1:0]         r_tile, w_tile_next;
  logic [c_entry_w-1:0]        r_entry, w_entry_next;
  logic [c_stall_w-1:0]        r_stall, w_stall_next;
  logic                        r_done, w_done_next;
  logic                        r_error, w_error_next;

  logic                        w_v;
  logic [c_tile_w-1:0]         w_tile;
  logic [cfg_addr_width_p-1:0] w_addr;
  logic [cfg_data_width_p-1:0] w_data;
  logic [cfg_data_width_p-1:0] w_core_data;
  logic                        w_hs;
  logic                        w_stalled;
  logic                        w_adv;

  logic [cfg_addr_width_p-1:0] w_ent_addr [num_entries_p];
  logic [cfg_data_width_p-1:0] w_ent_data [num_entries_p];

  // Unpack the flat table: entry e = {addr, data} at slice e
  for (genvar e = 0; e < num_entries_p; e++) begin : g_entry
    assign w_ent_addr[e] = cfg_table_i[e*c_ent_w + cfg_data_width_p +: cfg_addr_width_p];
    assign w_ent_data[e] = cfg_table_i[e*c_ent_w +: cfg_data_width_p];
  end

  // Core-id payload: current tile index zero-extended to the data width
  always_comb begin
    w_core_data                 = '0;
    w_core_data[c_tile_w-1:0]   = r_tile;
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_tile  <= '0;
      r_entry <= '0;
      r_stall <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tile  <= w_tile_next;
      r_entry <= w_entry_next;
      r_stall <= w_stall_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
    end
  end

  // Next-state, counter advance and timeout detection
  always_comb begin
    w_state_next = r_state;
    w_tile_next  = r_tile;
    w_entry_next = r_entry;
    w_done_next  = r_done;
    w_error_next = r_error;
    w_hs         = w_v & cfg_ready_i;
    w_stalled    = w_v & ~cfg_ready_i;
    w_adv        = 1'b0;
    w_stall_next = w_stalled ? (r_stall + c_stall_w'(1)) : '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_next = S_ENTRY;
          w_tile_next  = '0;
          w_entry_next = '0;
          w_done_next  = 1'b0;
        end
      end
      S_ENTRY: begin
        // Masked entries burn exactly one cycle with valid low
        w_adv = cfg_mask_i[r_entry] ? w_hs : 1'b1;
        if (w_adv) begin
          if (r_entry == c_last_entry) begin
            w_state_next = S_CORE_ID;
            w_entry_next = '0;
          end else begin
            w_entry_next = r_entry + c_entry_w'(1);
          end
        end
      end
      S_CORE_ID: begin
        if (w_hs) begin
          if (r_tile != c_last_tile) begin
            w_tile_next  = r_tile + c_tile_w'(1);
            w_entry_next = '0;
            w_state_next = S_ENTRY;
          end else begin
            w_tile_next  = '0;
            w_state_next = S_UNFREEZE;
          end
        end
      end
      S_UNFREEZE: begin
        if (w_hs) begin
          if (r_tile == c_last_tile) begin
            w_tile_next  = '0;
            w_done_next  = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_tile_next  = r_tile + c_tile_w'(1);
          end
        end
      end
      S_ERROR: begin
        w_state_next = S_ERROR;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A write stalled for timeout_p cycles abandons the sequence for good
    if ((timeout_p != 0) && w_stalled && (r_stall == c_stall_lim)) begin
      w_state_next = S_ERROR;
      w_error_next = 1'b1;
      w_stall_next = '0;
    end
  end

  // Link outputs decoded from registered state only, never from ready
  always_comb begin
    w_v    = 1'b0;
    w_tile = '0;
    w_addr = '0;
    w_data = '0;
    case (r_state)
      S_ENTRY: begin
        if (cfg_mask_i[r_entry]) begin
          w_v    = 1'b1;
          w_tile = r_tile;
          w_addr = w_ent_addr[r_entry];
          w_data = w_ent_data[r_entry];
        end
      end
      S_CORE_ID: begin
        w_v    = 1'b1;
        w_tile = r_tile;
        w_addr = core_id_addr_p;
        w_data = w_core_data;
      end
      S_UNFREEZE: begin
        w_v    = 1'b1;
        w_tile = r_tile;
        w_addr = freeze_addr_p;
        w_data = '0;
      end
      default: begin
        w_v = 1'b0;
      end
    endcase
  end

  assign cfg_v_o    = w_v;
  assign cfg_tile_o = w_tile;
  assign cfg_addr_o = w_addr;
  assign cfg_data_o = w_data;
  assign busy_o     = (r_state == S_ENTRY) || (r_state == S_CORE_ID) ||
                      (r_state == S_UNFREEZE);
  assign done_o     = r_done;
  assign error_o    = r_error;

endmodule
`default_nettype wire
